// File: rtl/prio_scan_pkg.sv
// rtl/prio_scan_pkg.sv - mode encodings and active-low hex glyph table for prio_enc_scan
package prio_scan_pkg;

    localparam logic [1:0] MODE_HI     = 2'b00;
    localparam logic [1:0] MODE_LO     = 2'b01;
    localparam logic [1:0] MODE_STICKY = 2'b10;

    // Entry n is the glyph for hex digit n; bits 7..1 = a..g, bit 0 = dp, 0 lights a segment.
    localparam logic [15:0][7:0] GLYPH_TABLE = {
        8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
        8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
    };

endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - combinational nibble to active-low 7-segment glyph
module hex7seg
    import prio_scan_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [7:0] seg_o
);

    assign seg_o = GLYPH_TABLE[nibble_i];

endmodule

// File: rtl/prio_enc_scan.sv
// rtl/prio_enc_scan.sv - debounced priority encoder with sticky-max mode and multiplexed hex display
module prio_enc_scan
    import prio_scan_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int IDX_W    = $clog2(WIDTH),
    parameter int DEBOUNCE = 4,
    parameter int SCAN_DIV = 1024,
    parameter int DIGITS   = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [WIDTH-1:0]  in,
    input  logic [1:0]        mode,
    input  logic              clr,
    output logic              indicator,
    output logic [IDX_W-1:0]  out,
    output logic              upd,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int NIB_W = 4 * DIGITS;

    logic [WIDTH-1:0]  sync1_q, sync2_q;
    logic [WIDTH-1:0]  cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic [IDX_W-1:0]  out_q, out_d;
    logic              ind_q, ind_d;
    logic              upd_q, upd_d;
    logic              sticky_q, sticky_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIG_W-1:0]  digit_q, digit_d;
    logic [7:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;

    logic [IDX_W-1:0]  hi_idx, lo_idx;
    logic              hi_any;
    logic [NIB_W-1:0]  out_ext;
    logic [3:0]        nibble;
    logic [7:0]        glyph;

    // The candidate load counts as the first equal sample, so acceptance
    // happens on the sample that brings the run length up to DEBOUNCE.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        s_d    = s_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
            if (DEBOUNCE == 1) begin
                s_d = sync2_q;
            end
        end else begin
            if (int'(cnt_q) < DEBOUNCE) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (int'(cnt_q) + 2 >= DEBOUNCE) begin
                s_d = cand_q;
            end
        end
    end

    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        hi_any = |s_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (s_q[i]) hi_idx = IDX_W'(i);
        end
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (s_q[i]) lo_idx = IDX_W'(i);
        end
    end

    // Sticky mode keeps its running maximum in out_q/ind_q directly.
    always_comb begin
        out_d    = out_q;
        ind_d    = ind_q;
        sticky_d = (mode == MODE_STICKY);
        case (mode)
            MODE_STICKY: begin
                if (clr) begin
                    out_d = '0;
                    ind_d = 1'b0;
                end else if (!sticky_q) begin
                    out_d = hi_idx;
                    ind_d = hi_any;
                end else if (hi_any && (!ind_q || hi_idx > out_q)) begin
                    out_d = hi_idx;
                    ind_d = 1'b1;
                end
            end
            MODE_LO: begin
                out_d = lo_idx;
                ind_d = hi_any;
            end
            default: begin
                out_d = hi_idx;
                ind_d = hi_any;
            end
        endcase
        upd_d = (out_d != out_q) || (ind_d != ind_q);
    end

    // Glyph and anode both derive from digit_d so they always land on the same edge.
    always_comb begin
        digit_d = digit_q;
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d = '0;
            if (digit_q == DIG_W'(DIGITS - 1)) begin
                digit_d = '0;
            end else begin
                digit_d = digit_q + DIG_W'(1);
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
        out_ext = NIB_W'(out_q);
        nibble  = out_ext[4*digit_d +: 4];
        seg_d   = ind_q ? glyph : 8'hFF;
        an_d    = ~(DIGITS'(1) << digit_d);
    end

    hex7seg u_hex7seg (
        .nibble_i (nibble),
        .seg_o    (glyph)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            s_q      <= '0;
            out_q    <= '0;
            ind_q    <= 1'b0;
            upd_q    <= 1'b0;
            sticky_q <= 1'b0;
            div_q    <= '0;
            digit_q  <= '0;
            seg_q    <= 8'hFF;
            an_q     <= ~DIGITS'(1);
        end else begin
            sync1_q  <= in;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            out_q    <= out_d;
            ind_q    <= ind_d;
            upd_q    <= upd_d;
            sticky_q <= sticky_d;
            div_q    <= div_d;
            digit_q  <= digit_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign indicator = ind_q;
    assign out       = out_q;
    assign upd       = upd_q;
    assign seg       = seg_q;
    assign an        = an_q;

endmodule

// File: tb/tb_prio_enc_scan.sv
// tb/tb_prio_enc_scan.sv - scoreboard bench for prio_enc_scan
module tb_prio_enc_scan;

    typedef struct packed {
        logic       ind;
        logic [2:0] idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] sw = 8'h00;
    logic [1:0] md = 2'b00;
    logic       clr_s = 1'b0;
    logic       indicator;
    logic [2:0] out;
    logic       upd;
    logic [7:0] seg;
    logic [1:0] an;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    prio_enc_scan #(
        .WIDTH    (8),
        .DEBOUNCE (4),
        .SCAN_DIV (4),
        .DIGITS   (2)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in        (sw),
        .mode      (md),
        .clr       (clr_s),
        .indicator (indicator),
        .out       (out),
        .upd       (upd),
        .seg       (seg),
        .an        (an)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_upd(input int budget, output bit seen, output int waited);
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < budget) begin
            tick(1);
            waited++;
            if (upd === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        tick(2);
        total++; if (out !== 3'd0)      begin bad++; $display("FAIL reset_out got=%0d exp=0", out); end
        total++; if (indicator !== 1'b0) begin bad++; $display("FAIL reset_ind got=%b exp=0", indicator); end
        total++; if (upd !== 1'b0)      begin bad++; $display("FAIL reset_upd got=%b exp=0", upd); end
        total++; if (seg !== 8'hFF)     begin bad++; $display("FAIL reset_seg got=%h exp=ff", seg); end
        total++; if (an !== 2'b10)      begin bad++; $display("FAIL reset_an got=%b exp=10", an); end
        resetn = 1'b1;
        tick(10);
    endtask

    task automatic test_highest;
        bit seen; int w; exp_t e; bit got0, got1;
        md = 2'b00; sw = 8'h24;
        sb.push_back('{ind: 1'b1, idx: 3'd5});
        wait_upd(20, seen, w);
        total++; if (!seen || w != 7) begin bad++; $display("FAIL hi_latency got=%0d seen=%b exp=7", w, seen); end
        e = sb.pop_front();
        total++; if ({indicator, out} !== e) begin bad++; $display("FAIL hi_result got=%b/%0d exp=%b/%0d", indicator, out, e.ind, e.idx); end
        tick(1);
        total++; if (upd !== 1'b0) begin bad++; $display("FAIL hi_upd_pulse got=%b exp=0", upd); end
        got0 = 0; got1 = 0;
        for (int k = 0; k < 10; k++) begin
            if (an === 2'b10) begin
                got0 = 1;
                total++; if (seg !== 8'h49) begin bad++; $display("FAIL hi_digit0 got=%h exp=49", seg); end
            end else if (an === 2'b01) begin
                got1 = 1;
                total++; if (seg !== 8'h03) begin bad++; $display("FAIL hi_digit1 got=%h exp=03", seg); end
            end
            tick(1);
        end
        total++; if (!(got0 && got1)) begin bad++; $display("FAIL hi_scan_seen got=%b%b exp=11", got1, got0); end
    endtask

    task automatic test_lowest;
        bit seen; int w; exp_t e; bit any_upd; bit got0;
        md = 2'b01;
        sb.push_back('{ind: 1'b1, idx: 3'd2});
        wait_upd(4, seen, w);
        total++; if (!seen || w != 1) begin bad++; $display("FAIL lo_mode_latency got=%0d exp=1", w); end
        e = sb.pop_front();
        total++; if ({indicator, out} !== e) begin bad++; $display("FAIL lo_result got=%b/%0d exp=%b/%0d", indicator, out, e.ind, e.idx); end
        tick(1);
        got0 = 0;
        for (int k = 0; k < 10; k++) begin
            if (an === 2'b10 && !got0) begin
                got0 = 1;
                total++; if (seg !== 8'h25) begin bad++; $display("FAIL lo_digit0 got=%h exp=25", seg); end
            end
            tick(1);
        end
        sw = 8'h00;
        sb.push_back('{ind: 1'b0, idx: 3'd0});
        wait_upd(20, seen, w);
        e = sb.pop_front();
        total++; if (!seen || w != 7 || {indicator, out} !== e) begin bad++; $display("FAIL lo_zero got=%b/%0d lat=%0d exp=0/0 lat=7", indicator, out, w); end
        sw = 8'h81;
        sb.push_back('{ind: 1'b1, idx: 3'd0});
        wait_upd(20, seen, w);
        e = sb.pop_front();
        total++; if (!seen || w != 7 || {indicator, out} !== e) begin bad++; $display("FAIL lo_bit0 got=%b/%0d lat=%0d exp=1/0 lat=7", indicator, out, w); end
        md = 2'b00;
        sb.push_back('{ind: 1'b1, idx: 3'd7});
        wait_upd(4, seen, w);
        e = sb.pop_front();
        total++; if (!seen || w != 1 || {indicator, out} !== e) begin bad++; $display("FAIL hi_bit7 got=%b/%0d lat=%0d exp=1/7 lat=1", indicator, out, w); end
        md = 2'b11;
        any_upd = 0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            if (upd !== 1'b0) any_upd = 1;
        end
        total++; if (any_upd || out !== 3'd7) begin bad++; $display("FAIL mode11 got=upd%b/%0d exp=upd0/7", any_upd, out); end
        md = 2'b00;
    endtask

    task automatic test_glitch;
        bit seen; int w; exp_t e; bit disturbed;
        sw = 8'h00;
        sb.push_back('{ind: 1'b0, idx: 3'd0});
        wait_upd(20, seen, w);
        e = sb.pop_front();
        total++; if (!seen || {indicator, out} !== e) begin bad++; $display("FAIL glitch_settle got=%b/%0d exp=0/0", indicator, out); end
        tick(2);
        sw = 8'h80;
        tick(3);
        sw = 8'h00;
        disturbed = 0;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            if (upd !== 1'b0 || out !== 3'd0 || indicator !== 1'b0) disturbed = 1;
        end
        total++; if (disturbed) begin bad++; $display("FAIL glitch_3 got=disturbed exp=unchanged"); end
        sw = 8'h80;
        sb.push_back('{ind: 1'b1, idx: 3'd7});
        sb.push_back('{ind: 1'b0, idx: 3'd0});
        tick(4);
        sw = 8'h00;
        // first upd edge is 7 after the step; 4 of those were spent above
        wait_upd(10, seen, w);
        e = sb.pop_front();
        total++; if (!seen || w != 3 || {indicator, out} !== e) begin bad++; $display("FAIL glitch_4_accept got=%b/%0d lat=%0d exp=1/7 lat=3", indicator, out, w); end
        wait_upd(10, seen, w);
        e = sb.pop_front();
        total++; if (!seen || w != 4 || {indicator, out} !== e) begin bad++; $display("FAIL glitch_4_release got=%b/%0d lat=%0d exp=0/0 lat=4", indicator, out, w); end
        tick(3);
    endtask

    task automatic test_sticky;
        bit seen; int w; exp_t e; bit disturbed;
        md = 2'b10; sw = 8'h08;
        sb.push_back('{ind: 1'b1, idx: 3'd3});
        wait_upd(9, seen, w);
        e = sb.pop_front();
        total++; if (!seen || w != 7 || {indicator, out} !== e) begin bad++; $display("FAIL sticky_3 got=%b/%0d lat=%0d exp=1/3 lat=7", indicator, out, w); end
        tick(3);
        sw = 8'h80;
        sb.push_back('{ind: 1'b1, idx: 3'd7});
        wait_upd(9, seen, w);
        e = sb.pop_front();
        total++; if (!seen || w != 7 || {indicator, out} !== e) begin bad++; $display("FAIL sticky_7 got=%b/%0d lat=%0d exp=1/7 lat=7", indicator, out, w); end
        tick(3);
        sw = 8'h02;
        disturbed = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (upd !== 1'b0 || out !== 3'd7 || indicator !== 1'b1) disturbed = 1;
        end
        total++; if (disturbed) begin bad++; $display("FAIL sticky_hold got=%b/%0d exp=1/7", indicator, out); end
        clr_s = 1'b1;
        sb.push_back('{ind: 1'b0, idx: 3'd0});
        sb.push_back('{ind: 1'b1, idx: 3'd1});
        tick(1);
        clr_s = 1'b0;
        e = sb.pop_front();
        total++; if (upd !== 1'b1 || {indicator, out} !== e) begin bad++; $display("FAIL sticky_clr got=%b/%0d upd=%b exp=0/0 upd=1", indicator, out, upd); end
        tick(1);
        e = sb.pop_front();
        total++; if (upd !== 1'b1 || {indicator, out} !== e) begin bad++; $display("FAIL sticky_recapture got=%b/%0d upd=%b exp=1/1 upd=1", indicator, out, upd); end
        md = 2'b00;
        tick(3);
        clr_s = 1'b1;
        tick(1);
        clr_s = 1'b0;
        tick(2);
        total++; if (upd !== 1'b0 || out !== 3'd1 || indicator !== 1'b1) begin bad++; $display("FAIL clr_nonsticky got=%b/%0d exp=1/1", indicator, out); end
    endtask

    task automatic test_scan;
        logic [1:0] prev_an; logic [7:0] prev_seg; int since; int changes;
        tick(1);
        prev_an = an; prev_seg = seg; since = -1; changes = 0;
        for (int k = 0; k < 24; k++) begin
            tick(1);
            if (since >= 0) since++;
            if (an !== prev_an) begin
                total++; if (an !== ~prev_an) begin bad++; $display("FAIL scan_onehot got=%b exp=%b", an, ~prev_an); end
                if (since >= 0) begin
                    total++; if (since != 4) begin bad++; $display("FAIL scan_period got=%0d exp=4", since); end
                end
                since = 0;
                changes++;
            end else begin
                total++; if (seg !== prev_seg) begin bad++; $display("FAIL scan_seg_alone got=%h exp=%h", seg, prev_seg); end
            end
            total++; if (seg !== ((an === 2'b10) ? 8'h9F : 8'h03)) begin bad++; $display("FAIL scan_glyph got=%h an=%b", seg, an); end
            prev_an = an; prev_seg = seg;
        end
        total++; if (changes < 5) begin bad++; $display("FAIL scan_changes got=%0d exp>=5", changes); end
    endtask

    task automatic test_reset_mid;
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        total++; if (out !== 3'd0 || indicator !== 1'b0) begin bad++; $display("FAIL mid_reset_out got=%b/%0d exp=0/0", indicator, out); end
        total++; if (seg !== 8'hFF || an !== 2'b10) begin bad++; $display("FAIL mid_reset_disp got=%h/%b exp=ff/10", seg, an); end
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            total++; if (an !== ((k < 4) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL resume_an edge=%0d got=%b exp=%b", k, an, (k < 4) ? 2'b10 : 2'b01); end
        end
    endtask

    initial begin
        test_reset();
        test_highest();
        test_lowest();
        test_glitch();
        test_sticky();
        test_scan();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prio_enc_scan.md
# prio_enc_scan

Parametrised, clocked priority encoder with an integrated multiplexed hex display driver. Synchronises and debounces a WIDTH-bit request/switch vector. Encodes it in one of three modes: highest-first, lowest-first, or sticky-max. Registers the index and a valid indicator, and scans the index across DIGITS active-low 7-segment digits. It sits between board switches/request lines and the board's segment/anode pins.

## Interface
- WIDTH, 8, input vector width; must be ≥ 2.
- IDX_W, $clog2(WIDTH), index width; derived, not overridden.
- DEBOUNCE, 4, consecutive identical synchronised samples required before a new input value is accepted; must be ≥ 1.
- SCAN_DIV, 1024, clocks each digit stays selected; must be ≥ 2.
- DIGITS, 2, number of hex digits displayed; must be ≥ ceil(IDX_W/4).

Ports:
- clk  in  1  the single clock; all state is on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in  in  WIDTH  raw request/switch vector; asynchronous to clk.
- mode  in  2  encoding mode: 00 highest-first, 01 lowest-first, 10 sticky-max, 11 treated as 00.
- clr  in  1  synchronous clear of the sticky state.
- indicator  out  1  1 when out holds a valid index.
- out  out  IDX_W  encoded index.
- upd  out  1  one-cycle pulse when out or indicator changes.
- seg  out  8  active-low segments; bit7..1 = a..g, bit0 = dp (dp always off, 1).
- an  out  DIGITS  active-low one-hot digit select; bit0 = least-significant hex digit.

## Operation
- Input path:
  - 2-FF synchroniser.
  - Then a stability filter: candidate register plus counter. The accepted value s is updated only after DEBOUNCE consecutive equal synchronised samples; any mismatch reloads the candidate and zeroes the counter.
- Encoding of s:
  - 00: index of highest set bit.
  - 01: index of lowest set bit.
  - s == 0: indicator=0, out=0.
- Sticky (10):
  - out tracks the maximum highest-set-bit index seen since the last clr or sticky entry.
  - indicator latches 1 once any bit is seen.
  - Entering sticky seeds from the current highest-first result.
- clr:
  - In sticky mode, next edge gives out=0, indicator=0.
  - Other modes: no effect.
  - clr and a new higher bit in the same cycle: clr wins; the bit is captured on the following cycle if still present in s.
- Mode change takes effect on the next edge; upd fires if the result differs.
- Display:
  - Each digit shows nibble k of out, zero-extended to 4·DIGITS bits, as a hex glyph (0–9, A, b, C, d, E, F).
  - indicator=0 gives seg=8'hFF on all digits; the scan continues.
- Scan:
  - Divider counts 0..SCAN_DIV-1; on wrap the digit index advances, wrapping DIGITS-1 → 0.
  - seg and an are registered together, so there is never a cycle with a mismatched glyph and anode.

## Timing
- Reset values:
  - out=0, indicator=0, upd=0, seg=8'hFF, an=~1 (digit 0).
  - Synchroniser, filter, sticky state and counters all zero.
- Latency: a clean step on in, held stable, appears on out/indicator exactly DEBOUNCE+3 edges after the edge that first samples it. upd is high in that same cycle only.
- Glitches shorter than DEBOUNCE synchronised cycles never reach out.
- seg reflects a new out value within 1 edge.
- Reset asserted mid-operation clears everything immediately (asynchronously). Deassertion resumes at digit 0, divider 0.

## Structure
- Shared package prio_scan_pkg holds:
  - the mode encoding constants (MODE_HI, MODE_LO, MODE_STICKY);
  - the 16-entry active-low glyph constant table.
- Sub-module hex7seg: 4-bit nibble → 8-bit active-low glyph, combinational, instantiated once on the muxed nibble.

## Test plan
All scenarios use WIDTH=8, DEBOUNCE=4, SCAN_DIV=4, DIGITS=2.
- **Reset mid-scan:** resetn low with activity in progress -> same cycle out=0, indicator=0, seg=8'hFF, an=2'b10.
- **Highest-first:** mode=00, in=8'h24 held -> after 7 edges out=5, indicator=1, single upd pulse; digit0 seg=8'h49, digit1 seg=8'h03.
- **Lowest-first:** mode=01, in=8'h24 -> out=2, digit0 seg=8'h25.
- **Glitch rejection:** in=8'h80 for 3 cycles, then 0 -> out, indicator and upd unchanged.
- **Sticky:** mode=10, in sequence 8'h08, 8'h80, 8'h02, each held 10 cycles -> out 3, then 7, then stays 7; then clr with in=8'h02 -> out=0, indicator=0 for one cycle, then out=1, indicator=1.
- **Scan:** steady state -> an alternates 2'b10/2'b01 every 4 cycles; seg changes only on the same edges as an.
